transition_scheduler: RTL and testbench
=======================================

# transition_scheduler

Generates the `ena` transition-select code that drives the synchronous model of an asynchronous circuit. Each cycle it chooses one excited signal (an environment input or a gate output whose next value differs from its current value) and fires it. It alternates fire and settle cycles so that excitation is always re-evaluated after a firing. It also counts firings and detects quiescence/deadlock, under single-step or free-run control from the testbench or host.

## Interface
Parameters:
- `N`, 8: number of transitions. Inputs occupy indices 0..NI-1, gates occupy NI..N-1.
- `NI`, 2: number of environment-input transitions.
- `ENA_W`, $clog2(N+1): width of `ena`. Code `N` means idle (no flop enabled).
- `CNT_W`, 16: width of the firing counter and the step budget.

Ports:
- `clk` input 1: clock.
- `reset` input 1: asynchronous, active-high reset.
- `excited` input N: per-transition excitation, computed combinationally from the circuit state.
- `env_en` input 1: when 0, input transitions 0..NI-1 are masked.
- `mode` input 1: 0 = round-robin, 1 = LFSR pseudo-random.
- `seed` input 16: LFSR seed, loaded on `start`.
- `start` input 1: pulse; begins a run with budget `budget`.
- `step` input 1: pulse; fires exactly one transition when in PAUSE.
- `budget` input CNT_W: maximum firings per run. 0 = unlimited.
- `ena` output ENA_W: transition select for the circuit model.
- `fired` output CNT_W: firings since the last `start`.
- `busy` output 1: high in RUN or SETTLE.
- `quiescent` output 1: no masked-excited transition remains.
- `done` output 1: one-cycle pulse when a run ends.

## Operation
- Masked request: `req = excited & {N{1}}`, with bits 0..NI-1 forced to 0 when `env_en` = 0.
- States:
  - IDLE: `ena` = N.
  - RUN: select and register a winner.
  - SETTLE: one cycle; `ena` returns to N.
  - PAUSE: wait for `step` or `start`.
- IDLE→RUN on `start`. Also clears `fired`, loads the LFSR with `seed` (0 is replaced by 16'h1), and resets the round-robin pointer to 0.
- RUN:
  - If `req` = 0: go to IDLE, pulse `done`, set `quiescent`.
  - Else: drive `ena` = winner index, increment `fired`, go to SETTLE.
- SETTLE→RUN, unless `fired` == `budget` (with `budget` ≠ 0): then go to IDLE and pulse `done`.
- PAUSE: entered from SETTLE when `step` was the trigger. `step` in PAUSE or IDLE performs one RUN/SETTLE pair.
- `start` in any state restarts the run.
- Round-robin: the winner is the first set `req` bit at or above `ptr`, wrapping at N. After each firing, `ptr` ← winner+1 mod N.
- Random: 16-bit Galois LFSR, taps 0xB400, advanced once per RUN cycle. The start offset is `lfsr mod N`, then a round-robin search from that offset. The `mod N` is implemented as repeated conditional subtraction, bounded to a single cycle.
- `fired` saturates at all-ones and does not wrap.
- `quiescent` is combinational: high when `req` = 0.

## Timing
- Reset values:
  - `ena` = N, `fired` = 0, `busy` = 0, `done` = 0.
  - State IDLE, `ptr` = 0, LFSR = 16'h1.
- `ena` is registered.
  - The code is valid for exactly one cycle.
  - The circuit flop updates at the edge that ends that cycle.
  - The following SETTLE cycle lets `excited` settle before the next sample.
- Maximum firing rate: 1 per 2 cycles.
- Latency from `start` to the first non-idle `ena`: 2 cycles.
- Simultaneous `start` and `step`: `start` wins.
- Reset mid-run: `ena` returns to N immediately (asynchronously). The firing in flight is abandoned.
- A `req` bit that drops between RUN and the firing edge is not re-checked. The caller must keep the excitation consistent.

## Structure
- Package `sched_pkg`:
  - state enum (IDLE, RUN, SETTLE, PAUSE)
  - LFSR taps and seed-zero substitute constant
  - idle-code function of N
- Sub-module `rr_pick`: N-bit request plus start offset in, winner index plus `found` out. Used for both modes.

## Test plan
- Reset asserted during RUN → `ena` = N, `fired` = 0, `busy` = 0 in the same cycle; state IDLE after release.
- N=4, mode 0, `excited` held at 4'b1011, `start` → `ena` sequence 0, N, 1, N, 3, N, 0…
- `excited` = 0 at `start` → `done` pulse 2 cycles later, `fired` = 0, `quiescent` = 1.
- `budget` = 3 with a permanently excited circuit → exactly 3 non-idle `ena` codes, then `done`, `fired` = 3.
- `env_en` = 0, NI = 2, `excited` = 4'b0011 → no firing; `done` and `quiescent` asserted.
- Mode 1, `seed` = 0: runs must be identical to runs with `seed` = 1. Over 1000 firings every excited index is chosen at least once.

Source files
------------

// File: rtl/sched_pkg.sv
// sched_pkg: shared state encoding, LFSR constants and helpers for the transition scheduler
package sched_pkg;
    typedef enum logic [1:0] {IDLE, RUN, SETTLE, PAUSE} state_t;
    localparam logic [15:0] lfsr_taps = 16'hB400;
    localparam logic [15:0] seed_zero_sub = 16'h0001;
    function automatic int idle_code(input int n);
        return n;
    endfunction
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? lfsr_taps : 16'h0000);
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: finds the first set request at or above a start offset, wrapping at N
module rr_pick #(
    parameter int N = 8,
    parameter int ENA_W = $clog2(N + 1)
) (
    input  logic [N-1:0]     req,
    input  logic [ENA_W-1:0] off,
    output logic [ENA_W-1:0] idx,
    output logic             found
);
    logic [N-1:0]     rot;
    logic [ENA_W-1:0] p;
    logic [ENA_W:0]   wrap;
    assign rot = N'({req, req} >> off);
    assign found = |req;
    // rotate so the offset sits at bit 0, take the lowest set bit, then rotate the index back
    always_comb begin
        p = '0;
        for (int i = N - 1; i >= 0; i--) p = rot[i] ? ENA_W'(i) : p;
        wrap = {1'b0, off} + {1'b0, p};
        idx = (wrap >= (ENA_W + 1)'(N)) ? ENA_W'(wrap - (ENA_W + 1)'(N)) : ENA_W'(wrap);
    end
endmodule

// File: rtl/transition_scheduler.sv
// transition_scheduler: picks and fires one excited transition per fire/settle pair
module transition_scheduler
    import sched_pkg::*;
#(
    parameter int N = 8,
    parameter int NI = 2,
    parameter int ENA_W = $clog2(N + 1),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     excited,
    input  logic             env_en,
    input  logic             mode,
    input  logic [15:0]      seed,
    input  logic             start,
    input  logic             step,
    input  logic [CNT_W-1:0] budget,
    output logic [ENA_W-1:0] ena,
    output logic [CNT_W-1:0] fired,
    output logic             busy,
    output logic             quiescent,
    output logic             done
);
    localparam logic [ENA_W-1:0] idle = ENA_W'(idle_code(N));
    localparam logic [N-1:0] in_mask = N'((64'd1 << NI) - 64'd1);
    state_t           state;
    logic             stepping;
    logic [ENA_W-1:0] ptr;
    logic [15:0]      lfsr;
    logic [31:0]      rem;
    logic [N-1:0]     req;
    logic [ENA_W-1:0] off;
    logic [ENA_W-1:0] win;
    logic             found;
    assign req = env_en ? excited : excited & ~in_mask;
    assign quiescent = ~|req;
    assign busy = (state == RUN) || (state == SETTLE);
    assign off = mode ? ENA_W'(rem) : ptr;
    // lfsr mod N by restoring conditional subtraction, unrolled into one cycle
    always_comb begin
        rem = {16'h0000, lfsr};
        for (int k = 15; k >= 0; k--) rem = (rem >= (32'(N) << k)) ? rem - (32'(N) << k) : rem;
    end
    rr_pick #(.N(N), .ENA_W(ENA_W)) pick (
        .req   (req),
        .off   (off),
        .idx   (win),
        .found (found)
    );
    // run control: start restarts from anywhere, step drives one RUN/SETTLE pair then parks in PAUSE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            stepping <= 1'b0;
            ptr <= '0;
            lfsr <= seed_zero_sub;
            ena <= idle;
            fired <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                state <= RUN;
                stepping <= 1'b0;
                ptr <= '0;
                lfsr <= (seed == 16'h0000) ? seed_zero_sub : seed;
                ena <= idle;
                fired <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= step ? RUN : IDLE;
                        stepping <= step ? 1'b1 : stepping;
                    end
                    RUN: begin
                        lfsr <= lfsr_step(lfsr);
                        if (!found) begin
                            state <= IDLE;
                            stepping <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            state <= SETTLE;
                            ena <= win;
                            fired <= (&fired) ? fired : fired + CNT_W'(1);
                            ptr <= (win == ENA_W'(N - 1)) ? '0 : win + ENA_W'(1);
                        end
                    end
                    SETTLE: begin
                        ena <= idle;
                        if (budget != '0 && fired == budget) begin
                            state <= IDLE;
                            stepping <= 1'b0;
                            done <= 1'b1;
                        end else begin
                            state <= stepping ? PAUSE : RUN;
                        end
                    end
                    PAUSE: state <= step ? RUN : PAUSE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_transition_scheduler.sv
// tb_transition_scheduler: directed self-checking bench for transition_scheduler with N=4, NI=2
module tb_transition_scheduler;
    localparam int N = 4;
    localparam int NI = 2;
    localparam int ENA_W = $clog2(N + 1);
    localparam int CNT_W = 16;
    localparam logic [ENA_W-1:0] idle = ENA_W'(N);
    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     excited;
    logic             env_en;
    logic             mode;
    logic [15:0]      seed;
    logic             start;
    logic             step;
    logic [CNT_W-1:0] budget;
    logic [ENA_W-1:0] ena;
    logic [CNT_W-1:0] fired;
    logic             busy;
    logic             quiescent;
    logic             done;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    transition_scheduler #(.N(N), .NI(NI), .ENA_W(ENA_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .excited   (excited),
        .env_en    (env_en),
        .mode      (mode),
        .seed      (seed),
        .start     (start),
        .step      (step),
        .budget    (budget),
        .ena       (ena),
        .fired     (fired),
        .busy      (busy),
        .quiescent (quiescent),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [15:0] model_lfsr(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    function automatic logic [ENA_W-1:0] model_pick(input logic [N-1:0] r, input int o);
        for (int i = 0; i < N; i++) if (r[(o + i) % N]) return ENA_W'((o + i) % N);
        return idle;
    endfunction

    task automatic test_reset();
        tick();
        tick();
        checks++; if (ena !== idle) begin failures++; $display("FAIL reset_ena: got %0d expected %0d", ena, idle); end
        checks++; if (fired !== 16'd0) begin failures++; $display("FAIL reset_fired: got %0d expected 0", fired); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        reset = 1'b0;
        excited = 4'b1111;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy: got %b expected 0", busy); end
        pulse_start();
        tick();
        checks++; if (ena !== 3'd0) begin failures++; $display("FAIL midrun_ena: got %0d expected 0", ena); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrun_busy: got %b expected 1", busy); end
        #2 reset = 1'b1;
        #1;
        checks++; if (ena !== idle) begin failures++; $display("FAIL async_reset_ena: got %0d expected %0d", ena, idle); end
        checks++; if (fired !== 16'd0) begin failures++; $display("FAIL async_reset_fired: got %0d expected 0", fired); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL async_reset_busy: got %b expected 0", busy); end
        #1 reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", busy); end
        tick();
        checks++; if (ena !== idle) begin failures++; $display("FAIL post_reset_ena: got %0d expected %0d", ena, idle); end
    endtask

    task automatic test_round_robin();
        logic [ENA_W-1:0] exp_seq [8] = '{3'd0, 3'd4, 3'd1, 3'd4, 3'd3, 3'd4, 3'd0, 3'd4};
        mode = 1'b0;
        budget = '0;
        env_en = 1'b1;
        excited = 4'b1011;
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (ena !== exp_seq[i]) begin failures++; $display("FAIL rr_seq[%0d]: got %0d expected %0d", i, ena, exp_seq[i]); end
        end
        checks++; if (fired !== 16'd4) begin failures++; $display("FAIL rr_fired: got %0d expected 4", fired); end
    endtask

    task automatic test_quiescent();
        excited = 4'b0000;
        pulse_start();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL quiet_done_early: got %b expected 0", done); end
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL quiet_done: got %b expected 1", done); end
        checks++; if (fired !== 16'd0) begin failures++; $display("FAIL quiet_fired: got %0d expected 0", fired); end
        checks++; if (quiescent !== 1'b1) begin failures++; $display("FAIL quiet_quiescent: got %b expected 1", quiescent); end
        checks++; if (ena !== idle) begin failures++; $display("FAIL quiet_ena: got %0d expected %0d", ena, idle); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL quiet_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_budget();
        int nonidle = 0;
        int done_cnt = 0;
        int done_at = -1;
        excited = 4'b1111;
        budget = 16'd3;
        pulse_start();
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (ena !== idle) nonidle++;
            if (done === 1'b1) begin done_cnt++; done_at = i; end
        end
        checks++; if (nonidle != 3) begin failures++; $display("FAIL budget_firings: got %0d expected 3", nonidle); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL budget_done_count: got %0d expected 1", done_cnt); end
        checks++; if (done_at != 6) begin failures++; $display("FAIL budget_done_cycle: got %0d expected 6", done_at); end
        checks++; if (fired !== 16'd3) begin failures++; $display("FAIL budget_fired: got %0d expected 3", fired); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL budget_busy: got %b expected 0", busy); end
        budget = '0;
    endtask

    task automatic test_env_mask();
        env_en = 1'b0;
        excited = 4'b0011;
        #1;
        checks++; if (quiescent !== 1'b1) begin failures++; $display("FAIL mask_quiescent: got %b expected 1", quiescent); end
        pulse_start();
        tick();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL mask_done: got %b expected 1", done); end
        checks++; if (fired !== 16'd0) begin failures++; $display("FAIL mask_fired: got %0d expected 0", fired); end
        checks++; if (ena !== idle) begin failures++; $display("FAIL mask_ena: got %0d expected %0d", ena, idle); end
        env_en = 1'b1;
        #1;
        checks++; if (quiescent !== 1'b0) begin failures++; $display("FAIL unmask_quiescent: got %b expected 0", quiescent); end
    endtask

    task automatic test_step();
        mode = 1'b0;
        excited = 4'b0000;
        pulse_start();
        tick();
        excited = 4'b1111;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        checks++; if (ena !== 3'd0) begin failures++; $display("FAIL step1_ena: got %0d expected 0", ena); end
        checks++; if (fired !== 16'd1) begin failures++; $display("FAIL step1_fired: got %0d expected 1", fired); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL pause_busy: got %b expected 0", busy); end
        tick();
        tick();
        checks++; if (ena !== idle) begin failures++; $display("FAIL pause_ena: got %0d expected %0d", ena, idle); end
        checks++; if (fired !== 16'd1) begin failures++; $display("FAIL pause_fired: got %0d expected 1", fired); end
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        checks++; if (ena !== 3'd1) begin failures++; $display("FAIL step2_ena: got %0d expected 1", ena); end
        checks++; if (fired !== 16'd2) begin failures++; $display("FAIL step2_fired: got %0d expected 2", fired); end
        tick();
        start = 1'b1;
        step = 1'b1;
        tick();
        start = 1'b0;
        step = 1'b0;
        checks++; if (fired !== 16'd0) begin failures++; $display("FAIL start_wins_fired: got %0d expected 0", fired); end
        tick();
        checks++; if (ena !== 3'd0) begin failures++; $display("FAIL start_wins_ena: got %0d expected 0", ena); end
        tick();
        tick();
        checks++; if (ena !== 3'd1) begin failures++; $display("FAIL freerun_ena: got %0d expected 1", ena); end
    endtask

    task automatic test_random();
        logic [15:0] l;
        logic [ENA_W-1:0] exp;
        int hits [N];
        mode = 1'b1;
        budget = '0;
        env_en = 1'b1;
        excited = 4'b1111;
        for (int s = 0; s < 2; s++) begin
            seed = 16'(s);
            pulse_start();
            l = 16'h0001;
            for (int k = 0; k < 20; k++) begin
                exp = model_pick(excited, int'(l % 16'(N)));
                l = model_lfsr(l);
                tick();
                checks++; if (ena !== exp) begin failures++; $display("FAIL rand_seed%0d[%0d]: got %0d expected %0d", s, k, ena, exp); end
                tick();
            end
        end
        for (int i = 0; i < N; i++) hits[i] = 0;
        excited = 4'b1101;
        seed = 16'hACE1;
        pulse_start();
        l = 16'hACE1;
        for (int k = 0; k < 1000; k++) begin
            exp = model_pick(excited, int'(l % 16'(N)));
            l = model_lfsr(l);
            tick();
            checks++; if (ena !== exp) begin failures++; $display("FAIL rand_long[%0d]: got %0d expected %0d", k, ena, exp); end
            if (ena < idle) hits[ena]++;
            tick();
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (excited[i] ? hits[i] == 0 : hits[i] != 0) begin
                failures++;
                $display("FAIL rand_cover[%0d]: got %0d hits, excited=%b", i, hits[i], excited[i]);
            end
        end
        checks++; if (fired !== 16'd1000) begin failures++; $display("FAIL rand_fired: got %0d expected 1000", fired); end
    endtask

    initial begin
        reset = 1'b1;
        excited = '0;
        env_en = 1'b1;
        mode = 1'b0;
        seed = '0;
        start = 1'b0;
        step = 1'b0;
        budget = '0;
        test_reset();
        test_round_robin();
        test_quiescent();
        test_budget();
        test_env_mask();
        test_step();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
